phy_tx_serial: RTL and testbench

- Transmit-side PHY. Takes 32-bit parallel words and stripes them across two serial lanes, data_out0 and data_out1, at one bit per clk_32f cycle, MSB first.
- Inserts the comma byte (0xBC) whenever no data is pending, so the downstream phy_rx can acquire and keep byte alignment.
- Sits between the byte/word datapath and the serial link. Its serial output drives phy_rx data_in0/data_in1 directly in loopback benches.

---
 rtl/phy_tx_serial.sv | 140 ++++++++++++++
 tb/tb_phy_tx_serial.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_serial.sv
// Transmit-side serial PHY. Stripes 32-bit words over two byte-aligned lanes,
// MSB first, one bit per clk_32f cycle. Comma bytes fill every slot that has
// no data, starting with a fixed comma preamble after reset.
//
// Handshake: a word transfers on a rising edge where valid_in && ready_out.
// ready_out depends only on registered state, never on valid_in. Upstream
// must hold data_in and valid_in stable until the word is accepted.
module phy_tx_serial #(
  parameter int         SYNC_COUNT = 4,
  parameter logic [7:0] COMMA      = 8'hBC
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out0,
  output logic        data_out1,
  output logic        active,
  output logic        sync_done,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ST_SYNC    = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_DATA_HI = 2'd2;
  localparam logic [1:0] ST_DATA_LO = 2'd3;

  localparam int             SCW       = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
  localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_COUNT - 1);

  logic [1:0]     state;
  logic [2:0]     bit_cnt;
  logic [SCW-1:0] sync_cnt;
  logic [31:0]    hold_word;
  logic           hold_full;
  logic [15:0]    lo_bytes;   // second byte slot of the word in flight: {lane0, lane1}
  logic [7:0]     byte0;
  logic [7:0]     byte1;

  logic           boundary;
  logic [1:0]     nxt_state;
  logic [7:0]     nb0;
  logic [7:0]     nb1;
  logic           nxt_active;
  logic           load;

  // A new byte starts on every edge where bit_cnt wraps back to zero.
  assign boundary  = (bit_cnt == 3'd0);
  assign ready_out = sync_done && !hold_full;
  assign state_dbg = state;

  // Decide the content of the byte slot that starts at the next boundary.
  always_comb begin
    nxt_state  = state;
    nb0        = COMMA;
    nb1        = COMMA;
    nxt_active = 1'b0;
    load       = 1'b0;
    case (state)
      ST_IDLE, ST_DATA_LO: begin
        if (hold_full) begin
          load       = 1'b1;
          nxt_state  = ST_DATA_HI;
          nb0        = hold_word[31:24];
          nb1        = hold_word[15:8];
          nxt_active = 1'b1;
        end else begin
          nxt_state = ST_IDLE;
        end
      end
      ST_DATA_HI: begin
        nxt_state  = ST_DATA_LO;
        nb0        = lo_bytes[15:8];
        nb1        = lo_bytes[7:0];
        nxt_active = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer: byte-slot state plus the comma preamble counter.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= ST_SYNC;
      sync_cnt  <= '0;
      sync_done <= 1'b0;
    end else if (state == ST_SYNC) begin
      if (bit_cnt == 3'd7) begin
        sync_cnt <= sync_cnt + SCW'(1);
        if (sync_cnt == SYNC_LAST) begin
          state     <= ST_IDLE;
          sync_done <= 1'b1;
        end
      end
    end else if (boundary) begin
      state <= nxt_state;
    end
  end

  // Lane serialisers: latch the byte at a boundary, then shift it out MSB first.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= 3'd0;
      byte0     <= 8'h00;
      byte1     <= 8'h00;
      lo_bytes  <= 16'h0000;
      data_out0 <= 1'b0;
      data_out1 <= 1'b0;
      active    <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (boundary) begin
        byte0     <= nb0;
        byte1     <= nb1;
        data_out0 <= nb0[7];
        data_out1 <= nb1[7];
        active    <= nxt_active;
        if (load) lo_bytes <= {hold_word[23:16], hold_word[7:0]};
      end else begin
        data_out0 <= byte0[3'd7 - bit_cnt];
        data_out1 <= byte1[3'd7 - bit_cnt];
      end
    end
  end

  // Single-entry holding register: filled on handshake, emptied on load.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      hold_word <= 32'h0;
      hold_full <= 1'b0;
    end else if (boundary && load) begin
      hold_full <= 1'b0;
    end else if (valid_in && ready_out) begin
      hold_word <= data_in;
      hold_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phy_tx_serial.sv
// Directed bench for phy_tx_serial. The expected serial stream is built as a
// queue of {active, lane0, lane1} triples from hand-worked word timing and is
// compared every cycle, 1 ns after the rising edge.
module tb_phy_tx_serial;

  localparam logic [7:0] COMMA = 8'hBC;

  logic        clk_32f;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        data_out0;
  logic        data_out1;
  logic        active;
  logic        sync_done;
  logic [1:0]  state_dbg;

  logic [2:0]  exp_q[$];
  int          n_checks;
  int          n_errors;
  int          cyc;

  phy_tx_serial #(.SYNC_COUNT(4), .COMMA(COMMA)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .active    (active),
    .sync_done (sync_done),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_bits(input logic [7:0] b0, input logic [7:0] b1, input logic act, input int n);
    for (int i = 7; i > 7 - n; i--) exp_q.push_back({act, b0[i], b1[i]});
  endtask

  task automatic push_comma(input int n);
    for (int i = 0; i < n; i++) push_bits(COMMA, COMMA, 1'b0, 8);
  endtask

  task automatic push_word(input logic [31:0] w);
    push_bits(w[31:24], w[15:8], 1'b1, 8);
    push_bits(w[23:16], w[7:0], 1'b1, 8);
  endtask

  // One clock: advance past the edge and compare the lanes against the queue.
  task automatic step();
    logic [2:0] e;
    @(posedge clk_32f);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("lanes", {29'd0, active, data_out0, data_out1}, {29'd0, e});
    end
  endtask

  // Present a word and hold it until an edge sees ready_out high.
  task automatic send_word(input logic [31:0] w);
    logic rdy;
    int   guard;
    data_in  = w;
    valid_in = 1'b1;
    guard    = 0;
    do begin
      rdy = ready_out;
      step();
      guard++;
    end while (!rdy && guard < 64);
    valid_in = 1'b0;
    check("accepted", {31'd0, rdy}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;

    // Reset state
    repeat (10) @(posedge clk_32f);
    #1;
    check("rst_d0", {31'd0, data_out0}, 32'd0);
    check("rst_d1", {31'd0, data_out1}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_sync", {31'd0, sync_done}, 32'd0);
    check("rst_ready", {31'd0, ready_out}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // Expected stream up to the mid-word reset.
    push_comma(5);               // edges 1..40: preamble + one idle comma
    push_word(32'hCAFEF00D);     // edges 41..56
    push_word(32'hDEADBEEF);     // edges 57..72, back to back
    push_comma(2);               // edges 73..88
    push_word(32'h11223344);     // edges 89..136 streamed
    push_word(32'h55667788);
    push_word(32'h99AABBCC);
    push_comma(1);               // edges 137..144
    push_word(32'hBCBC0000);     // edges 145..160
    push_comma(2);               // edges 161..176
    push_bits(8'h1F, 8'h3D, 1'b1, 5);  // edges 177..181, cut by reset

    // Release with a word already waiting: ignored until the preamble ends.
    reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 32'hCAFEF00D;
    cyc      = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      check("sync_done", {31'd0, sync_done}, {31'd0, cyc >= 32});
      check("ready_sync", {31'd0, ready_out}, {31'd0, cyc >= 32});
    end

    // Edge 33 accepts CAFEF00D; next word waits on a full holding register.
    step();
    check("ready_full", {31'd0, ready_out}, 32'd0);
    data_in = 32'hDEADBEEF;
    repeat (8) begin
      step();
      check("ready_hold", {31'd0, ready_out}, {31'd0, cyc == 41});
    end
    step();
    valid_in = 1'b0;
    check("ready_refull", {31'd0, ready_out}, 32'd0);
    check("state_hi", {30'd0, state_dbg}, 32'd2);

    while (cyc < 84) step();
    check("state_idle", {30'd0, state_dbg}, 32'd1);

    // Gap-free streaming of three words.
    send_word(32'h11223344);
    send_word(32'h55667788);
    send_word(32'h99AABBCC);
    while (cyc < 140) step();

    // Data bytes equal to the comma go out verbatim.
    send_word(32'hBCBC0000);
    while (cyc < 168) step();

    // Abort mid-word with a second word pending.
    send_word(32'h1F2E3D4C);
    send_word(32'h9ABCDEF0);
    check("ready_pending", {31'd0, ready_out}, 32'd0);
    while (cyc < 181) step();
    check("q_drained", exp_q.size(), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_d0", {31'd0, data_out0}, 32'd0);
    check("abort_d1", {31'd0, data_out1}, 32'd0);
    check("abort_active", {31'd0, active}, 32'd0);
    check("abort_sync", {31'd0, sync_done}, 32'd0);
    check("abort_ready", {31'd0, ready_out}, 32'd0);
    repeat (4) @(posedge clk_32f);
    #1;
    reset = 1'b1;
    cyc   = 0;

    // Preamble restarts; neither discarded word appears.
    push_comma(6);
    for (int i = 0; i < 48; i++) begin
      step();
      check("resync_done", {31'd0, sync_done}, {31'd0, cyc >= 32});
      check("resync_ready", {31'd0, ready_out}, {31'd0, cyc >= 32});
    end
    check("q_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
